// File: rtl/gng_mem_pkg.sv
// Shared types and defaults for the ROM download / game read arbiter.
package gng_mem_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ} arb_state_t;

    localparam int unsigned DEF_AW        = 19;
    localparam logic [31:0] DEF_SIGNATURE = 32'h10830080;

    // Byte idx of the signature, byte 0 being the most significant.
    function automatic logic [7:0] sig_byte(input logic [31:0] sig, input logic [1:0] idx);
        return sig[8 * (3 - int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/gng_dl_fifo.sv
// Small synchronous FIFO holding download (addr,data) pairs; push when full is ignored.
module gng_dl_fifo #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gng_rom_arbiter.sv
// Shares one memory port between buffered ROM-download writes (strict priority) and game reads,
// holds the game in reset around downloads and flags the alternate-ROM signature.
module gng_rom_arbiter
    import gng_mem_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RST_HOLD   = 16,
    parameter logic [31:0] SIGNATURE  = DEF_SIGNATURE
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_overflow,
    output logic          sig_match,
    output logic          game_rst,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          rd_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack
);

    localparam int unsigned FW = AW + 8;
    localparam int unsigned HW = $clog2(RST_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD);

    arb_state_t                    state;
    logic [FW-1:0]                 fifo_head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_pop;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          dl_active_q;
    logic                          dl_rise;
    logic                          sig_addr;
    logic [3:0]                    sig_flag;
    logic [HW-1:0]                 hold_cnt;
    logic                          busy;

    gng_dl_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .push  (dl_wr),
        .pop   (fifo_pop),
        .din   ({dl_addr, dl_data}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_pop  = (state == WRITE) && mem_ack;
    assign dl_rise   = dl_active && !dl_active_q;
    assign sig_addr  = (dl_addr[AW-1:2] == '0);
    assign sig_match = &sig_flag;
    assign busy      = dl_active || (fifo_count != '0) || (state == WRITE);
    assign game_rst  = busy || (hold_cnt != '0);

    // A write in the rise cycle lands after the clear, so its flag/overflow survives.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            dl_active_q <= 1'b0;
            dl_overflow <= 1'b0;
            sig_flag    <= '0;
        end else begin
            dl_active_q <= dl_active;
            if (dl_rise) begin
                dl_overflow <= 1'b0;
                sig_flag    <= '0;
            end
            if (dl_wr && fifo_full) dl_overflow <= 1'b1;
            if (dl_wr && sig_addr)
                sig_flag[dl_addr[1:0]] <= (dl_data == sig_byte(SIGNATURE, dl_addr[1:0]));
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= HOLD_LOAD;
        end else if (busy) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_ack    <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= fifo_head[FW-1:8];
                        mem_wdata <= fifo_head[7:0];
                    // rd_req is still high in the ack cycle; don't reissue that read.
                    end else if (rd_req && !game_rst && !rd_ack) begin
                        state    <= READ;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= rd_addr;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        rd_data <= mem_rdata;
                        rd_ack  <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gng_rom_arbiter.sv
// Self-checking bench for gng_rom_arbiter: acts as the memory controller and checks against a queue model.
module tb_gng_rom_arbiter;

    localparam int unsigned AW       = 19;
    localparam int          DEPTH    = 4;
    localparam int          RST_HOLD = 16;

    logic          clk_sys;
    logic          rst_n;
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_overflow;
    logic          sig_match;
    logic          game_rst;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ack;

    gng_rom_arbiter #(
        .AW         (AW),
        .FIFO_DEPTH (DEPTH),
        .RST_HOLD   (RST_HOLD),
        .SIGNATURE  (32'h10830080)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .dl_active   (dl_active),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_overflow (dl_overflow),
        .sig_match   (sig_match),
        .game_rst    (game_rst),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_ack      (rd_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    typedef struct {
        bit            act;
        bit            wr;
        logic [AW-1:0] a;
        logic [7:0]    d;
    } cyc_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] sigb [4] = '{8'h10, 8'h83, 8'h00, 8'h80};

    // Reference model state
    wr_t  mq[$];
    wr_t  exp_wr[$];
    bit   m_ovf;
    bit [3:0] m_flag;
    bit   m_act_q;
    int   m_age;
    int   cyc = 0;

    // Memory-controller side
    wr_t           seen_wr[$];
    logic [AW-1:0] seen_rd[$];
    int            ack_delay = 2;
    int            wait_cnt = 0;
    bit            ack_is_write = 0;
    logic [7:0]    rd_value = 8'h00;
    int            last_wr_ack_cyc = 0;

    cyc_t plan[$];

    // game_rst must be high while a download is live or buffered, and for RST_HOLD cycles after.
    function automatic bit exp_rst();
        return dl_active || (mq.size() != 0) || (m_age < RST_HOLD);
    endfunction

    always @(posedge clk_sys) begin
        cyc++;
        if (!rst_n) begin
            mq.delete();
            m_ovf   = 0;
            m_flag  = '0;
            m_act_q = 0;
            m_age   = 0;
        end else begin
            if (dl_active || mq.size() != 0) m_age = 0;
            else if (m_age < RST_HOLD) m_age++;
            if (dl_active && !m_act_q) begin
                m_ovf  = 0;
                m_flag = '0;
            end
            m_act_q = dl_active;
            if (dl_wr) begin
                if (dl_addr < 4) m_flag[dl_addr[1:0]] = (dl_data == sigb[dl_addr[1:0]]);
                if (mq.size() >= DEPTH) m_ovf = 1;
                else begin
                    mq.push_back({dl_addr, dl_data});
                    exp_wr.push_back({dl_addr, dl_data});
                end
            end
            if (mem_ack && ack_is_write && mq.size() != 0) mq.delete(0);
        end
    end

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk_sys);
            if (!rst_n) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    wait_cnt     = 0;
                    mem_ack      = 1'b1;
                    ack_is_write = mem_we;
                    if (mem_we) begin
                        seen_wr.push_back({mem_addr, mem_wdata});
                        last_wr_ack_cyc = cyc;
                    end else begin
                        seen_rd.push_back(mem_addr);
                        mem_rdata = rd_value;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk_sys);
        #2;
    endtask

    task automatic run_download(input bit timing_chk);
        bit fell;
        int fall_cyc;
        fell = 0;
        fall_cyc = 0;
        for (int n = 0; n < int'(plan.size()) + 600; n++) begin
            if (n < int'(plan.size())) begin
                dl_active = plan[n].act;
                dl_wr     = plan[n].wr;
                dl_addr   = plan[n].a;
                dl_data   = plan[n].d;
            end else begin
                dl_active = 1'b0;
                dl_wr     = 1'b0;
            end
            step();
            checks += 3;
            if (game_rst !== exp_rst()) begin
                errors++;
                $display("FAIL game_rst cyc %0d got %b exp %b", cyc, game_rst, exp_rst());
            end
            if (dl_overflow !== m_ovf) begin
                errors++;
                $display("FAIL dl_overflow cyc %0d got %b exp %b", cyc, dl_overflow, m_ovf);
            end
            if (sig_match !== (&m_flag)) begin
                errors++;
                $display("FAIL sig_match cyc %0d got %b exp %b", cyc, sig_match, &m_flag);
            end
            if (n >= int'(plan.size()) && game_rst === 1'b0) begin
                fell = 1;
                fall_cyc = cyc;
                break;
            end
        end
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        checks++;
        if (!fell) begin
            errors++;
            $display("FAIL drain_timeout got game_rst %b exp 0", game_rst);
        end
        if (timing_chk) begin
            checks++;
            if (fall_cyc != last_wr_ack_cyc + 1 + RST_HOLD) begin
                errors++;
                $display("FAIL rst_fall_time got %0d exp %0d", fall_cyc, last_wr_ack_cyc + 1 + RST_HOLD);
            end
        end
    endtask

    task automatic test_reset();
        int high;
        rst_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        repeat (3) step();
        checks += 5;
        if (game_rst !== 1'b1) begin errors++; $display("FAIL rst_game_rst got %b exp 1", game_rst); end
        if ({sig_match, dl_overflow, rd_ack} !== 3'b000) begin
            errors++; $display("FAIL rst_flags got %b exp 000", {sig_match, dl_overflow, rd_ack});
        end
        if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_mem_req got %b exp 00", {mem_req, mem_we}); end
        if ({mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL rst_mem_bus got %h exp 0", {mem_addr, mem_wdata});
        end
        if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", rd_data); end

        rst_n   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = AW'($urandom());
        #1;
        high = (game_rst === 1'b1) ? 1 : 0;
        for (int i = 1; i < 24; i++) begin
            step();
            if (game_rst === 1'b1) high++;
            checks += 2;
            if (game_rst !== exp_rst()) begin
                errors++; $display("FAIL hold_game_rst i %0d got %b exp %b", i, game_rst, exp_rst());
            end
            if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_during_rst i %0d got mem_req %b exp 0", i, mem_req); end
            if (i == 12) rd_req = 1'b0;
        end
        checks++;
        if (high != RST_HOLD) begin errors++; $display("FAIL hold_length got %0d exp %0d", high, RST_HOLD); end
    endtask

    task automatic test_signature();
        wr_t e;
        seen_wr.delete(); exp_wr.delete(); plan.delete();
        ack_delay = 2;
        plan.push_back(cyc_t'{1'b1, 1'b0, '0, 8'h00});
        for (int i = 0; i < 4; i++) plan.push_back(cyc_t'{1'b1, 1'b1, AW'(i), sigb[i]});
        run_download(1'b1);
        checks += 2;
        if (sig_match !== 1'b1) begin errors++; $display("FAIL sig_good got %b exp 1", sig_match); end
        if (seen_wr.size() != 4) begin errors++; $display("FAIL sig_wr_count got %0d exp 4", seen_wr.size()); end
        for (int i = 0; i < 4 && i < int'(seen_wr.size()); i++) begin
            e.a = AW'(i);
            e.d = sigb[i];
            checks++;
            if (seen_wr[i] !== e) begin errors++; $display("FAIL sig_wr%0d got %h exp %h", i, seen_wr[i], e); end
        end
    endtask

    task automatic test_overflow();
        wr_t e;
        logic [7:0] bytes [5];
        seen_wr.delete(); exp_wr.delete(); plan.delete();
        ack_delay = 20;
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom());
            plan.push_back(cyc_t'{1'b1, 1'b1, AW'(32'h100 + i), bytes[i]});
        end
        run_download(1'b0);
        checks += 2;
        if (dl_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", dl_overflow); end
        if (seen_wr.size() != 4) begin errors++; $display("FAIL ovf_wr_count got %0d exp 4", seen_wr.size()); end
        for (int i = 0; i < 4 && i < int'(seen_wr.size()); i++) begin
            e.a = AW'(32'h100 + i);
            e.d = bytes[i];
            checks++;
            if (seen_wr[i] !== e) begin errors++; $display("FAIL ovf_wr%0d got %h exp %h", i, seen_wr[i], e); end
        end
        ack_delay = 2;
    endtask

    task automatic test_bad_signature();
        logic [7:0] bad [4] = '{8'h00, 8'h83, 8'h00, 8'h80};
        plan.delete();
        plan.push_back(cyc_t'{1'b1, 1'b0, '0, 8'h00});
        for (int i = 0; i < 4; i++) plan.push_back(cyc_t'{1'b1, 1'b1, AW'(i), bad[i]});
        run_download(1'b0);
        checks += 2;
        if (sig_match !== 1'b0) begin errors++; $display("FAIL sig_bad got %b exp 0", sig_match); end
        if (dl_overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", dl_overflow); end
        plan.delete();
        for (int i = 0; i < 4; i++) plan.push_back(cyc_t'{1'b1, 1'b1, AW'(i), sigb[i]});
        run_download(1'b0);
        checks++;
        if (sig_match !== 1'b1) begin errors++; $display("FAIL sig_regood got %b exp 1", sig_match); end
    endtask

    task automatic test_read();
        logic [AW-1:0] a;
        logic [7:0]    d;
        bit            got;
        for (int t = 0; t < 6; t++) begin
            a = (t == 0) ? AW'(32'h1234) : AW'($urandom());
            d = (t == 0) ? 8'h5A : 8'($urandom());
            ack_delay = (t == 0) ? 2 : int'($urandom_range(1, 5));
            rd_value = d;
            seen_rd.delete();
            rd_addr = a;
            rd_req  = 1'b1;
            step();
            checks++;
            if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, a}) begin
                errors++; $display("FAIL rd_issue t %0d got %b%b %h exp 10 %h", t, mem_req, mem_we, mem_addr, a);
            end
            got = 0;
            for (int n = 0; n < 50; n++) begin
                if (mem_ack === 1'b1) begin got = 1; break; end
                checks++;
                if (rd_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack t %0d got %b exp 0", t, rd_ack); end
                step();
            end
            checks++;
            if (!got) begin errors++; $display("FAIL rd_ack_timeout t %0d got mem_ack %b exp 1", t, mem_ack); end
            step();
            checks += 3;
            if (rd_ack !== 1'b1) begin errors++; $display("FAIL rd_ack t %0d got %b exp 1", t, rd_ack); end
            if (rd_data !== d) begin errors++; $display("FAIL rd_data t %0d got %h exp %h", t, rd_data, d); end
            if (seen_rd.size() != 1 || seen_rd[0] !== a) begin
                errors++; $display("FAIL rd_addr t %0d got %0d reads exp 1 at %h", t, seen_rd.size(), a);
            end
            rd_req = 1'b0;
            step();
            checks += 2;
            if (rd_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse t %0d got %b exp 0", t, rd_ack); end
            if (rd_data !== d) begin errors++; $display("FAIL rd_data_hold t %0d got %h exp %h", t, rd_data, d); end
        end
        ack_delay = 2;
    endtask

    task automatic test_random_download();
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            n;
        for (int it = 0; it < 4; it++) begin
            seen_wr.delete(); exp_wr.delete(); plan.delete();
            ack_delay = int'($urandom_range(1, 4));
            n = int'($urandom_range(3, 10));
            for (int j = 0; j < n; j++) begin
                a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom());
                d = ($urandom_range(0, 1) == 1 && a < 4) ? sigb[a[1:0]] : 8'($urandom());
                plan.push_back(cyc_t'{1'b1, 1'b1, a, d});
                repeat ($urandom_range(0, 2)) plan.push_back(cyc_t'{1'b1, 1'b0, '0, 8'h00});
            end
            run_download(1'b0);
            checks++;
            if (seen_wr.size() != exp_wr.size()) begin
                errors++; $display("FAIL rnd_wr_count it %0d got %0d exp %0d", it, seen_wr.size(), exp_wr.size());
            end
            for (int i = 0; i < int'(seen_wr.size()) && i < int'(exp_wr.size()); i++) begin
                checks++;
                if (seen_wr[i] !== exp_wr[i]) begin
                    errors++; $display("FAIL rnd_wr it %0d idx %0d got %h exp %h", it, i, seen_wr[i], exp_wr[i]);
                end
            end
        end
        ack_delay = 2;
    endtask

    task automatic test_priority_reset();
        logic [7:0] d;
        bit         got;
        bit         stray;
        seen_wr.delete(); seen_rd.delete();
        ack_delay = 2;
        d = 8'($urandom());
        rd_value  = 8'hC3;
        dl_active = 1'b1; dl_wr = 1'b1; dl_addr = AW'(32'h40); dl_data = d;
        rd_req = 1'b1; rd_addr = AW'(32'h777);
        step();
        dl_wr = 1'b0; dl_active = 1'b0;
        got = 0;
        for (int n = 0; n < 10; n++) begin
            if (mem_req === 1'b1) begin got = 1; break; end
            step();
        end
        checks++;
        if (!got || {mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(32'h40), d}) begin
            errors++; $display("FAIL prio_first got %b %h %h exp 1 %h %h", mem_we, mem_addr, mem_wdata, AW'(32'h40), d);
        end
        got = 0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (rd_ack === 1'b1) begin got = 1; break; end
        end
        checks += 2;
        if (!got) begin errors++; $display("FAIL prio_rd_timeout got rd_ack %b exp 1", rd_ack); end
        if (seen_wr.size() != 1 || seen_rd.size() != 1 || rd_data !== 8'hC3) begin
            errors++; $display("FAIL prio_order got wr %0d rd %0d data %h exp 1 1 c3", seen_wr.size(), seen_rd.size(), rd_data);
        end
        rd_req = 1'b0;
        step();

        ack_delay = 20;
        dl_active = 1'b1; dl_wr = 1'b1; dl_addr = AW'(32'h50); dl_data = 8'($urandom());
        step();
        dl_addr = AW'(32'h51); dl_data = 8'($urandom());
        step();
        dl_wr = 1'b0; dl_active = 1'b0;
        got = 0;
        for (int n = 0; n < 10; n++) begin
            if (mem_req === 1'b1) begin got = 1; break; end
            step();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rstw_no_write got mem_req %b exp 1", mem_req); end
        step();
        rst_n = 1'b0;
        #1;
        checks += 2;
        if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL rstw_mem_req got %b exp 00", {mem_req, mem_we}); end
        if (game_rst !== 1'b1) begin errors++; $display("FAIL rstw_game_rst got %b exp 1", game_rst); end
        step();
        step();
        rst_n = 1'b1;
        ack_delay = 2;
        stray = 0;
        for (int n = 0; n < 30; n++) begin
            step();
            if (mem_req !== 1'b0) stray = 1;
            checks++;
            if (game_rst !== exp_rst()) begin
                errors++; $display("FAIL rstw_hold n %0d got %b exp %b", n, game_rst, exp_rst());
            end
        end
        checks++;
        if (stray) begin errors++; $display("FAIL rstw_fifo_empty got mem_req activity exp none"); end
    endtask

    initial begin
        test_reset();
        test_signature();
        test_overflow();
        test_bad_signature();
        test_read();
        test_random_download();
        test_priority_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
